aes_input_buffer: RTL and testbench

//  Upstream deserializer for the AES core. Packs 32-bit host words into a 128-bit key and a 128-bit text block.

---
 rtl/aes_pkg.sv | 10 +
 rtl/aes_word_packer.sv | 42 ++++
 rtl/aes_input_buffer.sv | 115 +++++++++++
 tb/tb_aes_input_buffer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared constants and state encoding for the AES input buffer.
package aes_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned NWORDS = 4;
    localparam int unsigned BLK_W  = WORD_W * NWORDS;

    typedef enum logic [2:0] {IDLE, KEY, TEXT, LOAD, WAIT} in_state_t;

endpackage

// File: rtl/aes_word_packer.sv
// Shadow register plus word counter that assembles NWORDS host words into one block.
module aes_word_packer #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned NWORDS = 4,
    localparam int unsigned CW    = $clog2(NWORDS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic                     clr,
    input  logic [WORD_W-1:0]        data,
    output logic [CW-1:0]            cnt,
    output logic                     full,
    output logic [WORD_W*NWORDS-1:0] blk
);

    logic [NWORDS-1:0][WORD_W-1:0] shadow;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow <= '0;
            cnt    <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (wr) begin
            shadow[cnt] <= data;
            cnt         <= full ? '0 : cnt + 1'b1;
        end
    end

    // Next write completes the group.
    assign full = (cnt == CW'(NWORDS - 1));

    // Block as it will look once the current word lands, so the caller can commit in the same edge.
    always_comb begin
        blk = '0;
        for (int unsigned k = 0; k < NWORDS; k++) begin
            blk[WORD_W*k +: WORD_W] = (CW'(k) == cnt) ? data : shadow[k];
        end
    end

endmodule

// File: rtl/aes_input_buffer.sv
// Packs host words into key and text blocks and hands them to the AES core with a load pulse.
module aes_input_buffer
    import aes_pkg::*;
#(
    parameter int unsigned WORD_W = aes_pkg::WORD_W,
    parameter int unsigned NWORDS = aes_pkg::NWORDS,
    localparam int unsigned BLK_W = WORD_W * NWORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_i,
    input  logic              key_sel_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic              core_busy_i,
    output logic              ready_o,
    output logic [BLK_W-1:0]  key_o,
    output logic [BLK_W-1:0]  text_o,
    output logic              ld_o,
    output logic              key_valid_o,
    output logic              err_o
);

    localparam int unsigned CW = $clog2(NWORDS);

    in_state_t        state, state_nxt;
    logic             acc, key_wr, txt_wr, key_clr, txt_clr;
    logic             key_commit, txt_commit, err_nxt;
    logic             key_full, txt_full;
    logic [CW-1:0]    key_cnt, txt_cnt;
    logic [BLK_W-1:0] key_blk, txt_blk;

    aes_word_packer #(.WORD_W(WORD_W), .NWORDS(NWORDS)) u_key_pack (
        .clk  (clk),
        .rst  (rst),
        .wr   (key_wr),
        .clr  (key_clr),
        .data (data_i),
        .cnt  (key_cnt),
        .full (key_full),
        .blk  (key_blk)
    );

    aes_word_packer #(.WORD_W(WORD_W), .NWORDS(NWORDS)) u_txt_pack (
        .clk  (clk),
        .rst  (rst),
        .wr   (txt_wr),
        .clr  (txt_clr),
        .data (data_i),
        .cnt  (txt_cnt),
        .full (txt_full),
        .blk  (txt_blk)
    );

    always_comb begin
        acc        = wr_i & ready_o;
        key_wr     = acc & key_sel_i & ((state == IDLE) | (state == KEY));
        txt_wr     = acc & ~key_sel_i & (((state == IDLE) & key_valid_o) | (state == TEXT));
        key_clr    = acc & ~key_sel_i & (state == KEY);
        txt_clr    = acc & key_sel_i & (state == TEXT);
        key_commit = key_wr & (state == KEY) & key_full;
        txt_commit = txt_wr & (state == TEXT) & txt_full;
        err_nxt    = wr_i & ~ready_o;
        state_nxt  = state;
        case (state)
            IDLE: if (acc) begin
                if (key_sel_i)        state_nxt = KEY;
                else if (key_valid_o) state_nxt = TEXT;
                else                  err_nxt   = 1'b1;
            end
            KEY: if (acc) begin
                if (!key_sel_i) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else if (key_full) begin
                    state_nxt = IDLE;
                end
            end
            TEXT: if (acc) begin
                if (key_sel_i) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else if (txt_full) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: state_nxt = WAIT;
            // Busy is only meaningful once the core has seen ld_o, so the ld_o cycle is not sampled.
            WAIT: if (!ld_o && !core_busy_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ready_o     <= 1'b0;
            key_o       <= '0;
            text_o      <= '0;
            ld_o        <= 1'b0;
            key_valid_o <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_o <= (state_nxt == IDLE) || (state_nxt == KEY) || (state_nxt == TEXT);
            ld_o    <= (state == LOAD);
            err_o   <= err_nxt;
            if (key_commit) begin
                key_o       <= key_blk;
                key_valid_o <= 1'b1;
            end
            if (txt_commit) text_o <= txt_blk;
        end
    end

endmodule

// File: tb/tb_aes_input_buffer.sv
// Scoreboard bench: stimulus queues expected ld/err events, a negedge monitor checks them.
module tb_aes_input_buffer;

    localparam logic [127:0] KEYA  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] TEXTA = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
    localparam logic [127:0] TEXTB = 128'h44444444_33333333_22222222_11111111;

    typedef struct {
        bit           is_ld;
        logic [127:0] key;
        logic [127:0] text;
    } exp_t;

    logic         clk, rst, wr_i, key_sel_i, core_busy_i;
    logic [31:0]  data_i;
    logic         ready_o, ld_o, key_valid_o, err_o;
    logic [127:0] key_o, text_o;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    exp_t        q[$];

    aes_input_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .wr_i        (wr_i),
        .key_sel_i   (key_sel_i),
        .data_i      (data_i),
        .core_busy_i (core_busy_i),
        .ready_o     (ready_o),
        .key_o       (key_o),
        .text_o      (text_o),
        .ld_o        (ld_o),
        .key_valid_o (key_valid_o),
        .err_o       (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push(input bit is_ld, input logic [127:0] k, input logic [127:0] t);
        exp_t e;
        e.is_ld = is_ld;
        e.key   = k;
        e.text  = t;
        q.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the word was sampled.
    task automatic send(input bit ks, input logic [31:0] d);
        wr_i      = 1'b1;
        key_sel_i = ks;
        data_i    = d;
        @(posedge clk);
        #1;
        wr_i = 1'b0;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_ready"}, 128'(ready_o), 128'(0));
        chk({tag, "_ld"}, 128'(ld_o), 128'(0));
        chk({tag, "_err"}, 128'(err_o), 128'(0));
        chk({tag, "_kv"}, 128'(key_valid_o), 128'(0));
        chk({tag, "_key"}, key_o, 128'(0));
        chk({tag, "_text"}, text_o, 128'(0));
    endtask

    task automatic send_keya();
        send(1'b1, 32'h03020100);
        send(1'b1, 32'h07060504);
        send(1'b1, 32'h0B0A0908);
        send(1'b1, 32'h0F0E0D0C);
    endtask

    // Monitor: every ld_o or err_o pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (ld_o || err_o) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: got ld=%0b err=%0b expected none", ld_o, err_o);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("event_ld", 128'(ld_o), 128'(e.is_ld));
                chk("event_err", 128'(err_o), 128'(!e.is_ld));
                if (e.is_ld) begin
                    chk("ld_key", key_o, e.key);
                    chk("ld_text", text_o, e.text);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; wr_i = 1'b0; key_sel_i = 1'b0; data_i = '0; core_busy_i = 1'b0;

        // 1: reset held, then released mid-cycle
        #12;
        chk_cleared("rst0");
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_release_ready", 128'(ready_o), 128'(1));

        // 2: key load
        send_keya();
        chk("key_o", key_o, KEYA);
        chk("key_valid", 128'(key_valid_o), 128'(1));
        chk("key_ready", 128'(ready_o), 128'(1));

        // 3: text block, load pulse, busy handshake, write during WAIT
        push(1'b1, KEYA, TEXTA);
        send(1'b0, 32'h33221100);
        send(1'b0, 32'h77665544);
        send(1'b0, 32'hBBAA9988);
        send(1'b0, 32'hFFEEDDCC);
        chk("load_ready", 128'(ready_o), 128'(0));
        chk("text_o", text_o, TEXTA);
        @(posedge clk); #1;
        chk("ld_high", 128'(ld_o), 128'(1));
        @(posedge clk); #1;
        chk("ld_one_cycle", 128'(ld_o), 128'(0));
        core_busy_i = 1'b1;
        push(1'b0, '0, '0);
        send(1'b0, 32'h55555555);
        chk("wait_text_hold", text_o, TEXTA);
        repeat (8) @(posedge clk);
        #1;
        chk("busy_ready", 128'(ready_o), 128'(0));
        core_busy_i = 1'b0;
        @(posedge clk); #1;
        chk("busy_release_ready", 128'(ready_o), 128'(1));

        // 4: reset, then text with no key
        #3 rst = 1'b0;
        #1 chk_cleared("rst1");
        #2 rst = 1'b1;
        @(posedge clk); #1;
        push(1'b0, '0, '0);
        send(1'b0, 32'hAAAA0000);
        @(posedge clk); #1;
        chk("nokey_ready", 128'(ready_o), 128'(1));
        chk("nokey_kv", 128'(key_valid_o), 128'(0));

        // 5: key abort by text word keeps the old key; next block uses it
        send_keya();
        send(1'b1, 32'hDEADBEEF);
        send(1'b1, 32'hCAFEF00D);
        push(1'b0, '0, '0);
        send(1'b0, 32'h12345678);
        chk("abort_key", key_o, KEYA);
        chk("abort_kv", 128'(key_valid_o), 128'(1));
        chk("abort_ready", 128'(ready_o), 128'(1));
        push(1'b1, KEYA, TEXTB);
        send(1'b0, 32'h11111111);
        send(1'b0, 32'h22222222);
        send(1'b0, 32'h33333333);
        send(1'b0, 32'h44444444);
        @(posedge clk); #1;
        @(posedge clk); #1;
        core_busy_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        core_busy_i = 1'b0;
        @(posedge clk); #1;
        chk("blk2_ready", 128'(ready_o), 128'(1));

        // 6: reset in the middle of a text group
        send(1'b0, 32'h01010101);
        send(1'b0, 32'h02020202);
        #3 rst = 1'b0;
        #1 chk_cleared("rst2");
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_ready", 128'(ready_o), 128'(1));

        chk("queue_drained", 128'(q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
